// File: rtl/lcs_job_sequencer.sv
// lcs_job_sequencer: loads one (n, m) job into an input buffer, runs the lcs kernel
// over ap_ctrl_hs, captures its writes and streams the result with valid/ready.
module lcs_job_sequencer #(
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 8,
    parameter int TIMEOUT   = 4096,
    localparam int IAW = $clog2(IN_DEPTH),
    localparam int OAW = $clog2(OUT_DEPTH),
    localparam int CW  = $clog2(TIMEOUT + 1)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [7:0]     cfg_n,
    input  logic [7:0]     cfg_m,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_data,
    output logic           ap_start,
    input  logic           ap_done,
    input  logic           ap_idle,
    input  logic           ap_ready,
    input  logic [IAW-1:0] data_in_address0,
    input  logic           data_in_ce0,
    output logic [7:0]     data_in_q0,
    input  logic [OAW-1:0] data_out_address0,
    input  logic           data_out_ce0,
    input  logic           data_out_we0,
    input  logic [7:0]     data_out_d0,
    output logic [31:0]    n,
    output logic [31:0]    m,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [7:0]     res_data,
    output logic           res_last,
    output logic [OAW:0]   res_len,
    output logic           job_done,
    output logic           job_err,
    output logic           fault
);
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN, FAULT} state_t;
    state_t         r_state;
    logic [7:0]     r_in_buf [IN_DEPTH];
    logic [7:0]     r_out_buf [OUT_DEPTH];
    logic [7:0]     r_n, r_m, r_q;
    logic [IAW-1:0] r_wr_ptr;
    logic [OAW-1:0] r_rd_ptr;
    logic [OAW:0]   r_res_len;
    logic [CW-1:0]  r_wd;
    logic           r_job_err;
    logic [8:0]     w_cfg_sum, w_len;
    logic [OAW:0]   w_wr_end;
    logic           w_cfg_bad, w_cfg_hs, w_in_hs, w_res_hs, w_wr, w_last, w_unused;
    assign w_unused  = ap_idle;
    assign w_cfg_sum = {1'b0, cfg_n} + {1'b0, cfg_m};
    assign w_len     = {1'b0, r_n} + {1'b0, r_m};
    assign w_cfg_bad = cfg_n == 8'd0 || cfg_m == 8'd0 || w_cfg_sum > 9'(IN_DEPTH);
    assign w_cfg_hs  = cfg_valid && cfg_ready;
    assign w_in_hs   = in_valid && in_ready;
    assign w_res_hs  = res_valid && res_ready;
    assign w_wr      = (r_state == START || r_state == RUN) && data_out_ce0 && data_out_we0;
    assign w_wr_end  = {1'b0, data_out_address0} + 1'b1;
    assign w_last    = {1'b0, r_rd_ptr} == r_res_len - 1'b1;
    assign cfg_ready  = r_state == IDLE;
    assign in_ready   = r_state == LOAD;
    assign ap_start   = r_state == START;
    assign fault      = r_state == FAULT;
    assign res_valid  = r_state == DRAIN && r_res_len != '0;
    assign res_data   = res_valid ? r_out_buf[r_rd_ptr] : 8'h00;
    assign res_last   = res_valid && w_last;
    assign job_done   = r_state == DRAIN && (r_res_len == '0 || (w_res_hs && w_last));
    assign job_err    = r_job_err;
    assign n          = {24'b0, r_n};
    assign m          = {24'b0, r_m};
    assign res_len    = r_res_len;
    assign data_in_q0 = r_q;
    // Buffers keep their contents across reset; only pointers and lengths are cleared.
    always_ff @(posedge clk) begin
        if (w_in_hs) r_in_buf[r_wr_ptr] <= in_data;
        if (w_wr) r_out_buf[data_out_address0] <= data_out_d0;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_res_len <= '0;
            r_wd      <= '0;
            r_job_err <= 1'b0;
        end else begin
            r_job_err <= w_cfg_hs && w_cfg_bad;
            if (data_in_ce0) r_q <= 9'(data_in_address0) < w_len ? r_in_buf[data_in_address0] : 8'h00;
            if (w_wr && w_wr_end > r_res_len) r_res_len <= w_wr_end;
            case (r_state)
                IDLE: if (w_cfg_hs && !w_cfg_bad) begin
                    r_n       <= cfg_n;
                    r_m       <= cfg_m;
                    r_wr_ptr  <= '0;
                    r_res_len <= '0;
                    r_state   <= LOAD;
                end
                LOAD: if (w_in_hs) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (9'(r_wr_ptr) == w_len - 9'd1) begin
                        r_wd    <= '0;
                        r_state <= START;
                    end
                end
                START, RUN: begin
                    r_wd <= r_wd + 1'b1;
                    if (ap_done) begin
                        r_rd_ptr <= '0;
                        r_state  <= DRAIN;
                    end else if (r_wd == CW'(TIMEOUT - 1)) r_state <= FAULT;
                    else if (r_state == START && ap_ready) r_state <= RUN;
                end
                DRAIN: if (r_res_len == '0) r_state <= IDLE;
                else if (w_res_hs) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    if (w_last) r_state <= IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcs_job_sequencer.sv
// tb_lcs_job_sequencer: header table, directed corner cases and random jobs
// checked against a job-level model of buffers, lengths and stream contents.
module tb_lcs_job_sequencer;
    localparam int IN_DEPTH = 16, OUT_DEPTH = 8, TIMEOUT = 64, IAW = 4, OAW = 3;
    logic clk = 0, rstn = 0;
    logic cfg_valid = 0, in_valid = 0, ap_done = 0, ap_idle = 1, ap_ready = 0;
    logic data_in_ce0 = 0, data_out_ce0 = 0, data_out_we0 = 0, res_ready = 0;
    logic [7:0] cfg_n = 0, cfg_m = 0, in_data = 0, data_out_d0 = 0;
    logic [IAW-1:0] data_in_address0 = 0;
    logic [OAW-1:0] data_out_address0 = 0;
    logic cfg_ready, in_ready, ap_start, res_valid, res_last, job_done, job_err, fault;
    logic [7:0] data_in_q0, res_data;
    logic [31:0] n, m;
    logic [OAW:0] res_len;

    lcs_job_sequencer #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_n(cfg_n), .cfg_m(cfg_m),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .data_in_address0(data_in_address0), .data_in_ce0(data_in_ce0),
        .data_in_q0(data_in_q0), .data_out_address0(data_out_address0), .data_out_ce0(data_out_ce0),
        .data_out_we0(data_out_we0), .data_out_d0(data_out_d0), .n(n), .m(m), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_last(res_last), .res_len(res_len),
        .job_done(job_done), .job_err(job_err), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; logic [7:0] d; bit we;} wr_t;
    typedef struct {logic [7:0] n; logic [7:0] m; bit err;} vec_t;
    int total = 0, bad = 0;
    logic [7:0] inb [IN_DEPTH];
    logic [7:0] ob [OUT_DEPTH];
    int nm = 0, olen = 0;
    logic [7:0] ln = 0, lm = 0;
    logic [7:0] in_q [$];
    wr_t wq [$];
    vec_t tbl [7];
    logic [7:0] nom [13] = '{"A","T","C","T","G","A","T","T","G","C","A","T","A"};
    logic [7:0] tcta [4] = '{"T","C","T","A"};

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    function automatic bit bad_hdr(input logic [7:0] a, input logic [7:0] b);
        return a == 0 || b == 0 || int'(a) + int'(b) > IN_DEPTH;
    endfunction

    task automatic do_reset;
        cfg_valid = 0; in_valid = 0; ap_done = 0; ap_ready = 0; data_in_ce0 = 0;
        data_out_ce0 = 0; data_out_we0 = 0; res_ready = 0;
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        ln = 0; lm = 0; olen = 0;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ap_start", ap_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_job_done", job_done, 0);
        chk("rst_job_err", job_err, 0);
        chk("rst_fault", fault, 0);
        chk("rst_n", n, 0);
        chk("rst_m", m, 0);
        chk("rst_res_len", res_len, 0);
        chk("rst_q0", data_in_q0, 0);
    endtask

    task automatic hdr(input logic [7:0] n_i, input logic [7:0] m_i, input bit err);
        chk("hdr_cfg_ready", cfg_ready, 1);
        cfg_valid = 1; cfg_n = n_i; cfg_m = m_i;
        @(negedge clk);
        cfg_valid = 0;
        if (!err) begin ln = n_i; lm = m_i; olen = 0; end
        chk("hdr_job_err", job_err, err);
        chk("hdr_stay_idle", cfg_ready, err);
        chk("hdr_n", n, {24'b0, ln});
        chk("hdr_m", m, {24'b0, lm});
        @(negedge clk);
        chk("hdr_err_pulse", job_err, 0);
        chk("hdr_no_start", ap_start, 0);
        if (err) chk("hdr_err_ready", cfg_ready, 1);
    endtask

    task automatic load(input bit gaps);
        nm = in_q.size();
        for (int i = 0; i < nm; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin in_valid = 0; @(negedge clk); end
            chk("load_in_ready", in_ready, 1);
            in_valid = 1; in_data = in_q[i]; inb[i] = in_q[i];
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    task automatic writes;
        foreach (wq[i]) begin
            data_out_ce0 = 1; data_out_we0 = wq[i].we;
            data_out_address0 = OAW'(wq[i].addr); data_out_d0 = wq[i].d;
            if (wq[i].we) begin
                ob[wq[i].addr] = wq[i].d;
                if (wq[i].addr + 1 > olen) olen = wq[i].addr + 1;
            end
            @(negedge clk);
        end
        data_out_ce0 = 0; data_out_we0 = 0;
    endtask

    task automatic kernel(input int hold, input bit fast);
        int g = 0;
        while (!ap_start && g < 8) begin @(negedge clk); g++; end
        chk("ap_start_up", ap_start, 1);
        for (int a = 0; a <= IN_DEPTH; a++) begin
            if (a > 0) chk("rd_sweep", data_in_q0, (a - 1 < nm) ? inb[a - 1] : 8'h00);
            data_in_ce0 = a < IN_DEPTH;
            data_in_address0 = IAW'(a);
            @(negedge clk);
        end
        for (int h = 0; h < hold; h++) begin chk("start_held", ap_start, 1); @(negedge clk); end
        if (fast) begin
            writes();
            ap_ready = 1; ap_done = 1;
            @(negedge clk);
            ap_ready = 0; ap_done = 0;
        end else begin
            ap_ready = 1;
            @(negedge clk);
            ap_ready = 0;
            chk("start_drop", ap_start, 0);
            writes();
            ap_done = 1;
            @(negedge clk);
            ap_done = 0;
        end
    endtask

    task automatic drain(input int sb, input int sl, input bit rnd);
        int beat = 0, st = 0, g = 0;
        bit r;
        if (olen == 0) begin
            chk("empty_done", job_done, 1);
            chk("empty_valid", res_valid, 0);
            @(negedge clk);
        end else begin
            while (beat < olen && g < 300) begin
                r = rnd ? 1'($urandom_range(0, 1)) : !(beat == sb && st < sl);
                res_ready = r;
                #1;
                chk("res_valid", res_valid, 1);
                chk("res_data", res_data, ob[beat]);
                chk("res_last", res_last, beat == olen - 1);
                chk("res_job_done", job_done, r && beat == olen - 1);
                if (r) beat++;
                else if (beat == sb) st++;
                @(negedge clk);
                g++;
            end
            res_ready = 0;
            chk("drain_bound", beat, olen);
        end
        chk("done_pulse_end", job_done, 0);
        chk("back_idle", cfg_ready, 1);
        chk("res_len", res_len, olen);
    endtask

    task automatic run_job(input logic [7:0] n_i, input logic [7:0] m_i, input bit err, input bit rnd);
        wr_t w;
        data_out_ce0 = 1; data_out_we0 = 1;
        data_out_address0 = OAW'($urandom); data_out_d0 = 8'($urandom);
        @(negedge clk);
        data_out_ce0 = 0; data_out_we0 = 0;
        chk("idle_write_ignored", res_len, olen);
        hdr(n_i, m_i, err);
        if (!err) begin
            in_q.delete();
            for (int i = 0; i < n_i + m_i; i++) in_q.push_back(8'($urandom));
            wq.delete();
            repeat ($urandom_range(0, 6)) begin
                w.addr = int'($urandom_range(0, OUT_DEPTH - 1));
                w.d = 8'($urandom);
                w.we = $urandom_range(0, 3) != 0;
                wq.push_back(w);
            end
            load(rnd);
            kernel(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            drain(-1, 0, rnd);
        end
    endtask

    task automatic nominal(input bit bp);
        wr_t w;
        hdr(8'd7, 8'd6, 0);
        in_q.delete();
        foreach (nom[i]) in_q.push_back(nom[i]);
        load(0);
        data_in_ce0 = 1; data_in_address0 = 4'd13;
        @(negedge clk);
        chk("rd_addr13", data_in_q0, 8'h00);
        data_in_address0 = 4'd7;
        @(negedge clk);
        chk("rd_addr7", data_in_q0, "T");
        data_in_ce0 = 0; data_in_address0 = 4'd13;
        @(negedge clk);
        chk("rd_hold", data_in_q0, "T");
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            w.addr = i; w.d = tcta[i]; w.we = 1;
            wq.push_back(w);
        end
        kernel(2, 0);
        drain(bp ? 2 : -1, 3, 0);
        chk("nom_res_len", res_len, 4);
        chk("nom_n", n, 7);
        chk("nom_m", m, 6);
    endtask

    initial begin
        int early;
        logic [7:0] rn, rm;
        tbl[0] = '{8'd0, 8'd6, 1'b1};
        tbl[1] = '{8'd10, 8'd8, 1'b1};
        tbl[2] = '{8'd6, 8'd0, 1'b1};
        tbl[3] = '{8'd255, 8'd255, 1'b1};
        tbl[4] = '{8'd8, 8'd8, 1'b0};
        tbl[5] = '{8'd9, 8'd8, 1'b1};
        tbl[6] = '{8'd1, 8'd1, 1'b0};
        do_reset();
        foreach (tbl[i]) run_job(tbl[i].n, tbl[i].m, tbl[i].err, 0);
        nominal(1);
        hdr(8'd7, 8'd6, 0);
        in_q.delete();
        for (int i = 0; i < 5; i++) in_q.push_back(nom[i]);
        load(0);
        do_reset();
        nominal(0);
        hdr(8'd2, 8'd3, 0);
        in_q.delete();
        for (int i = 0; i < 5; i++) in_q.push_back(8'($urandom));
        load(0);
        early = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (fault || !ap_start) early++;
            @(negedge clk);
        end
        chk("wd_early", early, 0);
        chk("wd_fault", fault, 1);
        chk("wd_start_low", ap_start, 0);
        chk("wd_cfg_ready", cfg_ready, 0);
        cfg_valid = 1; cfg_n = 1; cfg_m = 1; in_valid = 1; res_ready = 1; ap_done = 1;
        repeat (3) begin
            @(negedge clk);
            chk("flt_cfg_ready", cfg_ready, 0);
            chk("flt_in_ready", in_ready, 0);
            chk("flt_res_valid", res_valid, 0);
            chk("flt_job_done", job_done, 0);
            chk("flt_sticky", fault, 1);
        end
        do_reset();
        nominal(0);
        repeat (40) begin
            if ($urandom_range(0, 4) == 0) begin
                rn = 8'($urandom_range(0, 20));
                rm = 8'($urandom_range(0, 20));
            end else begin
                rn = 8'($urandom_range(1, 15));
                rm = 8'($urandom_range(1, 16 - rn));
            end
            run_job(rn, rm, bad_hdr(rn, rm), 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcs_job_sequencer.md
Name: lcs_job_sequencer

Overview:
Controller that sequences the `lcs` HLS kernel (ap_ctrl_hs) for one job at a time. It accepts a job header (n, m) and a byte stream of seq0 followed by seq1, and holds them in an input buffer that it serves to the kernel's data_in memory port. It then starts the kernel and captures the kernel's data_out writes into a result buffer. Finally it streams the LCS string to a consumer with valid/ready, with a watchdog against a hung kernel.

Parameters:
IN_DEPTH, 16, input buffer bytes; n+m must not exceed it; kernel input address width = clog2(IN_DEPTH)
OUT_DEPTH, 8, result buffer bytes; kernel output address width = clog2(OUT_DEPTH)
TIMEOUT, 4096, maximum cycles in START+RUN before a fault

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  synchronous active-low reset
cfg_valid  in  1  job header valid
cfg_ready  out  1  header accepted when valid&&ready
cfg_n  in  8  length of seq0
cfg_m  in  8  length of seq1
in_valid  in  1  sequence byte valid
in_ready  out  1  sequence byte accepted when valid&&ready
in_data  in  8  sequence byte; seq0 bytes first, then seq1
ap_start  out  1  kernel start
ap_done  in  1  kernel done
ap_idle  in  1  kernel idle; status only, not used for sequencing
ap_ready  in  1  kernel accepted start
data_in_address0  in  clog2(IN_DEPTH)  kernel read address
data_in_ce0  in  1  kernel read enable
data_in_q0  out  8  kernel read data
data_out_address0  in  clog2(OUT_DEPTH)  kernel write address
data_out_ce0  in  1  kernel write chip enable
data_out_we0  in  1  kernel write enable
data_out_d0  in  8  kernel write data
n  out  32  zero-extended latched cfg_n
m  out  32  zero-extended latched cfg_m
res_valid  out  1  result byte valid
res_ready  in  1  result byte accepted
res_data  out  8  result byte
res_last  out  1  marks the final result byte
res_len  out  clog2(OUT_DEPTH)+1  result length, valid from job_done until the next header
job_done  out  1  one-cycle pulse at job completion
job_err  out  1  one-cycle pulse on header rejection
fault  out  1  sticky watchdog fault; cleared only by rstn

Behaviour:
- Reset, applied at posedge with rstn=0:
  - state=IDLE.
  - All outputs 0 except cfg_ready=1.
  - n=m=0, res_len=0, counters 0.
  - Buffer contents are not reset.
  - Reset mid-operation aborts the job; ap_start drops on the same edge.
- State IDLE: cfg_ready=1.
  - On handshake, if cfg_n==0, cfg_m==0, or cfg_n+cfg_m>IN_DEPTH (9-bit sum): job_err=1 for one cycle, stay in IDLE.
  - Otherwise latch n/m, clear wr_ptr and res_len, go to LOAD.
- State LOAD: in_ready=1.
  - Each accepted byte is written to in_buf[wr_ptr], then wr_ptr++.
  - The handshake on byte n+m-1 moves the machine to START.
  - Headers are not accepted (cfg_ready=0) outside IDLE.
- State START: ap_start=1.
  - ap_ready=1 → RUN, with ap_start=0 from the next cycle.
  - ap_done=1, with or without ap_ready → DRAIN.
- State RUN: ap_start=0; ap_done=1 → DRAIN.
- Watchdog:
  - Counter clears on entry to START and increments each cycle in START/RUN.
  - When it reaches TIMEOUT with no ap_done: go to FAULT, fault=1, ap_start=0.
  - FAULT is held until rstn. All handshake readies are 0 in FAULT.
- Kernel read port:
  - One-cycle latency: if data_in_ce0, then data_in_q0 <= (addr < n+m) ? in_buf[addr] : 8'h00.
  - Otherwise data_in_q0 holds its value.
  - Reads are served in every state.
- Kernel write port:
  - Active only in START/RUN, when data_out_ce0 && data_out_we0.
  - Writes out_buf[addr] <= d0, and sets res_len <= max(res_len, addr+1).
  - Writes in any other state are ignored.
- State DRAIN:
  - If res_len==0: job_done=1 and go to IDLE with no stream beats.
  - Otherwise res_valid=1, res_data=out_buf[rd_ptr], res_last=(rd_ptr==res_len-1).
  - rd_ptr advances on each handshake.
  - res_data and res_last stay stable while res_valid && !res_ready.
  - The handshake on the last beat pulses job_done (same cycle as that beat's handshake) and returns to IDLE.
- n and m outputs hold their value from the header handshake until the next accepted header or reset.

Test Plan:
- Nominal job, with a kernel model producing "TCTA":
  - Stimulus: header n=7,m=6; bytes "ATCTGAT"+"TGCATA".
  - Required: ap_start high until ap_ready; n=7, m=6.
  - Required: stream 'T','C','T','A' with res_last on 'A'; res_len=4; a single job_done pulse.
- Bad headers:
  - n=0,m=6 → job_err pulse, ap_start never rises, cfg_ready stays 1.
  - n=10,m=8 → job_err pulse, ap_start never rises, cfg_ready stays 1.
- Read port, after loading the nominal job:
  - data_in_ce0 with addr 7 → data_in_q0='T' one cycle later.
  - addr 13 → 8'h00.
  - ce0=0 → previous value held.
- Backpressure: res_ready low for 3 cycles at beat 2 → res_data='T' and res_valid held; the full stream completes intact.
- Watchdog: TIMEOUT=64 with a kernel that never asserts done → fault=1 exactly 64 cycles after START entry; ap_start=0; cfg_ready=0 until rstn pulse, after which a nominal job passes.
- Reset mid-LOAD:
  - rstn low for 1 cycle after 5 bytes → next cycle state=IDLE, cfg_ready=1, job_done=0.
  - A fresh nominal job then returns "TCTA".
